demux1to3_32b_buf: RTL and testbench

Registered 1-to-3 demultiplexer for 32-bit words, the routing counterpart of the 3:1 datapath selectors: a single producer's word is steered by a 2-bit select to one of three consumers, each behind a one-entry output buffer with valid/ready handshake. It sits between a shared result source (e.g. ALU or memory data) and three independent destination stages so that a stalled consumer never blocks the other two. Illegal select code 2'b11 is accepted, discarded and counted.

---
 rtl/demux1to3_32b_buf_pkg.sv | 26 ++
 rtl/demux1to3_32b_buf_chan_buf_32b.sv | 39 +++
 rtl/demux1to3_32b_buf.sv | 115 +++++++++++
 tb/tb_demux1to3_32b_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux1to3_32b_buf_pkg.sv
// Shared constants and helpers for the 1-to-3 buffered word demultiplexer.
package demux1to3_32b_buf_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;
   localparam int NUM_CH = 3;

   localparam logic [1:0] SEL_CH0     = 2'b00;
   localparam logic [1:0] SEL_CH1     = 2'b01;
   localparam logic [1:0] SEL_CH2     = 2'b10;
   localparam logic [1:0] SEL_ILLEGAL = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/demux1to3_32b_buf_chan_buf_32b.sv
// One-entry output buffer for a single channel: holds one word until the
// consumer takes it. slot_free tells the top whether a fill could land this
// cycle (empty, or being drained at the same edge).
module chan_buf_32b
   import demux1to3_32b_buf_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              slot_free
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;

   // Fill has priority over drain so a simultaneous drain+fill keeps the slot full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         data_r  <= 32'h0;
      end else if (fill) begin
         valid_r <= 1'b1;
         data_r  <= fill_data;
      end else if (valid_r && out_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign slot_free = !valid_r || out_ready;
   assign out_data  = data_r;
   assign out_valid = valid_r;

endmodule

// File: rtl/demux1to3_32b_buf.sv
// Registered 1-to-3 demultiplexer: steers a producer word to one of three
// buffered consumers; select code 2'b11 is swallowed and counted.
module demux1to3_32b_buf
   import demux1to3_32b_buf_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic              out_valid0,
   output logic              out_valid1,
   output logic              out_valid2,
   input  logic              out_ready0,
   input  logic              out_ready1,
   input  logic              out_ready2,
   output logic              err,
   input  logic              clr_err,
   output logic [CNT_W-1:0]  drop_cnt
);

   logic [NUM_CH-1:0] sel_onehot_s;
   logic [NUM_CH-1:0] slot_free_s;
   logic [NUM_CH-1:0] fill_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              illegal_acc_s;
   logic              err_r;
   logic [CNT_W-1:0]  drop_cnt_r;

   // Decode the select into a one-hot channel enable; the illegal code selects nothing.
   always_comb begin
      sel_onehot_s = 3'b000;
      case (in_sel)
         SEL_CH0: sel_onehot_s = 3'b001;
         SEL_CH1: sel_onehot_s = 3'b010;
         SEL_CH2: sel_onehot_s = 3'b100;
         default: sel_onehot_s = 3'b000;
      endcase
   end

   // Ready looks only at the addressed channel so a stalled neighbour never blocks.
   always_comb begin
      in_ready_s = 1'b1;
      case (in_sel)
         SEL_CH0: in_ready_s = slot_free_s[0];
         SEL_CH1: in_ready_s = slot_free_s[1];
         SEL_CH2: in_ready_s = slot_free_s[2];
         default: in_ready_s = 1'b1;
      endcase
   end

   assign in_ready      = in_ready_s;
   assign accept_s      = in_valid && in_ready_s;
   assign fill_s        = sel_onehot_s & {NUM_CH{accept_s}};
   assign illegal_acc_s = accept_s && (in_sel == SEL_ILLEGAL);

   chan_buf_32b u_ch0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (fill_s[0]),
      .fill_data (in_data),
      .out_ready (out_ready0),
      .out_data  (out_data0),
      .out_valid (out_valid0),
      .slot_free (slot_free_s[0])
   );

   chan_buf_32b u_ch1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (fill_s[1]),
      .fill_data (in_data),
      .out_ready (out_ready1),
      .out_data  (out_data1),
      .out_valid (out_valid1),
      .slot_free (slot_free_s[1])
   );

   chan_buf_32b u_ch2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (fill_s[2]),
      .fill_data (in_data),
      .out_ready (out_ready2),
      .out_data  (out_data2),
      .out_valid (out_valid2),
      .slot_free (slot_free_s[2])
   );

   // Sticky error flag and saturating drop counter; a clear beats a coincident drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r      <= 1'b0;
         drop_cnt_r <= 8'h00;
      end else if (clr_err) begin
         err_r      <= 1'b0;
         drop_cnt_r <= 8'h00;
      end else if (illegal_acc_s) begin
         err_r      <= 1'b1;
         drop_cnt_r <= sat_inc(drop_cnt_r);
      end else begin
         err_r      <= err_r;
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign err      = err_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_demux1to3_32b_buf.sv
// Scoreboard bench for demux1to3_32b_buf: the stimulus side pushes every
// accepted word onto its channel's queue, the monitor pops on each consumer
// handshake and compares the presented word.
module tb_demux1to3_32b_buf;

   logic        clk;
   logic        reset_n;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data0, out_data1, out_data2;
   logic        out_valid0, out_valid1, out_valid2;
   logic        out_ready0, out_ready1, out_ready2;
   logic        err;
   logic        clr_err;
   logic [7:0]  drop_cnt;

   int n_checks;
   int n_fail;

   // reference model: queue of words owed to each consumer, plus error state
   logic [31:0] sb[3][$];
   logic        exp_err;
   int          exp_drop;
   logic        mon_en;

   demux1to3_32b_buf dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data0  (out_data0),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_valid0 (out_valid0),
      .out_valid1 (out_valid1),
      .out_valid2 (out_valid2),
      .out_ready0 (out_ready0),
      .out_ready1 (out_ready1),
      .out_ready2 (out_ready2),
      .err        (err),
      .clr_err    (clr_err),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_data(input int k);
      case (k)
         0:       return out_data0;
         1:       return out_data1;
         default: return out_data2;
      endcase
   endfunction

   function automatic logic get_valid(input int k);
      case (k)
         0:       return out_valid0;
         1:       return out_valid1;
         default: return out_valid2;
      endcase
   endfunction

   function automatic logic get_ready(input int k);
      case (k)
         0:       return out_ready0;
         1:       return out_ready1;
         default: return out_ready2;
      endcase
   endfunction

   // Monitor: compare presented words against the scoreboard, pop on handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid%0d", k), {31'd0, get_valid(k)},
                {31'd0, sb[k].size() != 0});
            if (sb[k].size() != 0) begin
               chk($sformatf("out_data%0d", k), get_data(k), sb[k][0]);
               if (get_ready(k)) void'(sb[k].pop_front());
            end
         end
         chk("err", {31'd0, err}, {31'd0, exp_err});
         chk("drop_cnt", {24'd0, drop_cnt}, exp_drop);
      end
   end

   // One producer cycle: drive, then after the monitor has run decide acceptance.
   task automatic cyc(input logic [31:0] d, input logic [1:0] s, input logic v,
                      input logic [2:0] ordy, input logic clr);
      logic exp_rdy;
      @(posedge clk); #1;
      in_data = d; in_sel = s; in_valid = v;
      out_ready0 = ordy[0]; out_ready1 = ordy[1]; out_ready2 = ordy[2];
      clr_err = clr;
      @(negedge clk); #1;
      if (s == 2'b11) exp_rdy = 1'b1;
      else            exp_rdy = (sb[s].size() == 0);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (v && exp_rdy && s != 2'b11) sb[s].push_back(d);
      if (clr) begin
         exp_err = 1'b0; exp_drop = 0;
      end else if (v && exp_rdy && s == 2'b11) begin
         exp_err = 1'b1;
         exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
      end
   endtask

   // Watchdog so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0;
      exp_err = 1'b0; exp_drop = 0; mon_en = 1'b0;
      in_data = 32'h0; in_sel = 2'b00; in_valid = 1'b0; clr_err = 1'b0;
      out_ready0 = 1'b0; out_ready1 = 1'b0; out_ready2 = 1'b0;
      reset_n = 1'b0;
      #23;
      // reset state
      chk("rst out_valid0", {31'd0, out_valid0}, 32'd0);
      chk("rst out_valid1", {31'd0, out_valid1}, 32'd0);
      chk("rst out_valid2", {31'd0, out_valid2}, 32'd0);
      chk("rst out_data1", out_data1, 32'h0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst drop_cnt", {24'd0, drop_cnt}, 32'd0);
      for (int s = 0; s < 4; s++) begin
         in_sel = s[1:0]; #1;
         chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_en = 1'b1;

      // single word to ch1
      cyc(32'hDEADBEEF, 2'b01, 1'b1, 3'b010, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b010, 1'b0);

      // ch0 backpressure then release
      cyc(32'h1, 2'b00, 1'b1, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) cyc(32'h2, 2'b00, 1'b1, 3'b000, 1'b0);
      // ch0 blocked, ch2 still accepts
      cyc(32'hA5, 2'b10, 1'b1, 3'b000, 1'b0);
      cyc(32'h2, 2'b00, 1'b1, 3'b001, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b000, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b101, 1'b0);

      // back-to-back to ch1
      for (int i = 0; i < 4; i++) cyc(32'h1000 + i, 2'b01, 1'b1, 3'b010, 1'b0);
      cyc(32'h0, 2'b01, 1'b0, 3'b010, 1'b0);

      // illegal select flood, saturation, then clear
      for (int i = 0; i < 300; i++) cyc($urandom, 2'b11, 1'b1, 3'b000, 1'b0);
      cyc(32'h0, 2'b11, 1'b1, 3'b000, 1'b1);
      cyc(32'h0, 2'b00, 1'b0, 3'b000, 1'b0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [1:0] s;
         s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         cyc($urandom, s, 1'($urandom_range(0, 3) != 0), 3'($urandom),
             ($urandom_range(0, 40) == 0));
      end

      // asynchronous reset while ch0 and ch2 hold words
      cyc(32'h0, 2'b00, 1'b0, 3'b111, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b000, 1'b0);
      cyc(32'h11, 2'b00, 1'b1, 3'b000, 1'b0);
      cyc(32'h22, 2'b10, 1'b1, 3'b000, 1'b0);
      cyc(32'h0, 2'b11, 1'b1, 3'b000, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #2;
      mon_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("arst out_valid0", {31'd0, out_valid0}, 32'd0);
      chk("arst out_valid2", {31'd0, out_valid2}, 32'd0);
      chk("arst out_data0", out_data0, 32'h0);
      chk("arst out_data2", out_data2, 32'h0);
      chk("arst err", {31'd0, err}, 32'd0);
      for (int k = 0; k < 3; k++) sb[k].delete();
      exp_err = 1'b0; exp_drop = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_en = 1'b1;
      cyc(32'h77, 2'b00, 1'b1, 3'b000, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b001, 1'b0);
      cyc(32'h0, 2'b00, 1'b0, 3'b000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
